// File: rtl/fpm_round_stage.sv
// Normalise / round-to-nearest-even / pack stage behind the binary32 multiplier datapath.
// Two register stages with a valid/ready handshake; stage 1 normalises, stage 2 rounds and packs.
module fpm_round_stage #(
   parameter int EXP_W  = 10,
   parameter int MANT_W = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_sign,
   input  logic [EXP_W-1:0]      in_exp_sum,
   input  logic [2*MANT_W-1:0]   in_mant_prod,
   input  logic                  in_zero,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_result,
   output logic                  out_overflow,
   output logic                  out_underflow,
   output logic                  out_inexact
);

   localparam int PW = 2 * MANT_W;
   localparam int EW = EXP_W + 2;

   logic v1, v2;
   logic adv1, adv2;

   logic              s1_sign, s1_zero, s1_g, s1_s;
   logic [MANT_W-1:0] s1_mant;
   logic [EXP_W:0]    s1_exp;

   logic [MANT_W-1:0] n_mant;
   logic              n_g, n_s;
   logic [EXP_W:0]    n_exp;

   logic              up;
   logic [MANT_W:0]   m25;
   logic [EW-1:0]     e2;
   logic [MANT_W-2:0] frac;
   logic              ovf, unf;
   logic [31:0]       nxt_result;
   logic              nxt_ovf, nxt_unf, nxt_inx;

   // Stage 2 drains when empty or when the consumer takes the result;
   // stage 1 may then refill in the same cycle.
   assign adv2      = !v2 || out_ready;
   assign adv1      = !v1 || adv2;
   assign in_ready  = adv1;
   assign out_valid = v2;

   // Normalise: the product of two normalised significands has its MSB at bit 47 or 46.
   // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
   always_comb begin
      n_mant = in_mant_prod[PW-2 -: MANT_W];
      n_g    = in_mant_prod[MANT_W-2];
      n_s    = |in_mant_prod[MANT_W-3:0];
      if (in_mant_prod[PW-1]) begin
         n_mant = in_mant_prod[PW-1 -: MANT_W];
         n_g    = in_mant_prod[MANT_W-1];
         n_s    = |in_mant_prod[MANT_W-2:0];
      end
      n_exp = {in_exp_sum[EXP_W-1], in_exp_sum}
            + {{EXP_W{1'b0}}, in_mant_prod[PW-1]};
   end

   // Round to nearest, ties to even; a carry out of the significand bumps the exponent.
   always_comb begin
      up   = s1_g && (s1_s || s1_mant[0]);
      m25  = {1'b0, s1_mant} + {{MANT_W{1'b0}}, up};
      e2   = {s1_exp[EXP_W], s1_exp} + {{(EW-1){1'b0}}, m25[MANT_W]};
      frac = m25[MANT_W] ? m25[MANT_W-1:1] : m25[MANT_W-2:0];
      ovf  = !e2[EW-1] && (e2 >= EW'(255));
      unf  = e2[EW-1] || (e2 == '0);

      nxt_result = {s1_sign, e2[7:0], frac};
      nxt_ovf    = 1'b0;
      nxt_unf    = 1'b0;
      nxt_inx    = s1_g || s1_s;
      if (s1_zero) begin
         nxt_result = 32'h0000_0000;
         nxt_inx    = 1'b0;
      end else if (ovf) begin
         nxt_result = {s1_sign, 8'hFF, 23'h0};
         nxt_ovf    = 1'b1;
         nxt_inx    = 1'b1;
      end else if (unf) begin
         nxt_result = {s1_sign, 31'h0};
         nxt_unf    = 1'b1;
         nxt_inx    = 1'b1;
      end
   end

   // Control and output registers.
   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1            <= 1'b0;
         v2            <= 1'b0;
         out_result    <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
         out_inexact   <= 1'b0;
      end else begin
         if (adv1) v1 <= in_valid;
         if (adv2) v2 <= v1;
         if (adv2 && v1) begin
            out_result    <= nxt_result;
            out_overflow  <= nxt_ovf;
            out_underflow <= nxt_unf;
            out_inexact   <= nxt_inx;
         end
      end
   end

   // NOTE: stage-1 payload needs no reset; it is only ever observed behind v1.
   always_ff @(posedge clk) begin
      if (adv1 && in_valid) begin
         s1_sign <= in_sign;
         s1_zero <= in_zero;
         s1_mant <= n_mant;
         s1_g    <= n_g;
         s1_s    <= n_s;
         s1_exp  <= n_exp;
      end
   end

endmodule

// File: tb/tb_fpm_round_stage.sv
// Bench for fpm_round_stage: directed vectors, backpressure, mid-stream reset and a
// randomized run scored against an arithmetic reference model.
module tb_fpm_round_stage;

   localparam int EXP_W  = 10;
   localparam int MANT_W = 24;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [EXP_W-1:0]    in_exp_sum = '0;
   logic [2*MANT_W-1:0] in_mant_prod = '0;
   logic        in_zero = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_overflow, out_underflow, out_inexact;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      logic        inx;
   } res_t;

   typedef struct packed {
      logic        s;
      logic [9:0]  es;
      logic [47:0] p;
      logic        z;
   } op_t;

   res_t exp_q[$];
   res_t got_q[$];

   always #5 clk = ~clk;

   fpm_round_stage #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sign      (in_sign),
      .in_exp_sum   (in_exp_sum),
      .in_mant_prod (in_mant_prod),
      .in_zero      (in_zero),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_overflow (out_overflow),
      .out_underflow(out_underflow),
      .out_inexact  (out_inexact)
   );

   // Reference: value = P * 2^(exp_sum-127-46); keep 24 significant bits, round the
   // discarded remainder against exactly one half ulp.
   function automatic res_t model(input op_t o);
      res_t r;
      longint unsigned p, q, rem, half;
      int sh, e;
      r = '0;
      if (o.z) return r;
      p    = 64'(o.p);
      sh   = (p >= 64'h8000_0000_0000) ? 24 : 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      e    = int'($signed(o.es)) + (sh - 23);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255)     r = '{res: {o.s, 8'hFF, 23'h0}, ovf: 1'b1, unf: 1'b0, inx: 1'b1};
      else if (e <= 0)  r = '{res: {o.s, 31'h0},        ovf: 1'b0, unf: 1'b1, inx: 1'b1};
      else              r = '{res: {o.s, 8'(e), q[22:0]}, ovf: 1'b0, unf: 1'b0, inx: (rem != 0)};
      return r;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      o.s = 1'($urandom);
      o.es = 10'($urandom_range(0, 507) - 126);
      o.p = {2'($urandom_range(1, 3)), 14'($urandom), 32'($urandom)};
      case ($urandom_range(0, 5))
         0: o.p[21:0] = '0;               // possible tie when MSB is bit 46
         1: o.p[22:0] = '0;               // possible tie when MSB is bit 47
         2: o.p[46:23] = '1;              // near rounding carry
         default: ;
      endcase
      o.z = ($urandom_range(0, 15) == 0);
      return o;
   endfunction

   task automatic drive(input op_t o, input logic v);
      in_valid     = v;
      in_sign      = o.s;
      in_exp_sum   = o.es;
      in_mant_prod = o.p;
      in_zero      = o.z;
   endtask

   // One clock: sample handshakes mid-cycle, then advance past the rising edge.
   task automatic step(output bit acc);
      op_t cur;
      @(negedge clk);
      acc = !rst && in_valid && in_ready;
      cur = '{s: in_sign, es: in_exp_sum, p: in_mant_prod, z: in_zero};
      if (acc) exp_q.push_back(model(cur));
      if (!rst && out_valid && out_ready)
         got_q.push_back({out_result, out_overflow, out_underflow, out_inexact});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bit acc;
      rst = 1'b1;
      drive('0, 1'b0);
      step(acc);
      step(acc);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else n_pass++;
      n_checks++; if (out_result !== 32'h0) $display("FAIL reset_out_result got=%h want=00000000", out_result); else n_pass++;
      n_checks++;
      if ({out_overflow, out_underflow, out_inexact} !== 3'b000)
         $display("FAIL reset_flags got=%b want=000", {out_overflow, out_underflow, out_inexact});
      else n_pass++;
      rst = 1'b0;
      step(acc);
   endtask

   task automatic test_latency();
      bit acc;
      out_ready = 1'b1;
      drive('{s: 1'b0, es: 10'd127, p: 48'h9000_0000_0000, z: 1'b0}, 1'b1);
      step(acc);
      n_checks++; if (acc !== 1'b1) $display("FAIL latency_accept got=%b want=1", acc); else n_pass++;
      drive('0, 1'b0);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL latency_early got=%b want=0", out_valid); else n_pass++;
      step(acc);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL latency_valid got=%b want=1", out_valid); else n_pass++;
      n_checks++; if (out_result !== 32'h4010_0000) $display("FAIL latency_result got=%h want=40100000", out_result); else n_pass++;
      step(acc);
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_directed();
      op_t  ops[7];
      res_t want[7];
      bit   acc;
      int   idx = 0;
      int   cyc = 0;
      ops[0] = '{s: 1'b0, es: 10'd127, p: 48'h9000_0000_0000, z: 1'b0}; want[0] = '{res: 32'h4010_0000, ovf: 1'b0, unf: 1'b0, inx: 1'b0};
      ops[1] = '{s: 1'b0, es: 10'd127, p: 48'h4000_0040_0000, z: 1'b0}; want[1] = '{res: 32'h3F80_0000, ovf: 1'b0, unf: 1'b0, inx: 1'b1};
      ops[2] = '{s: 1'b0, es: 10'd127, p: 48'h4000_00C0_0000, z: 1'b0}; want[2] = '{res: 32'h3F80_0002, ovf: 1'b0, unf: 1'b0, inx: 1'b1};
      ops[3] = '{s: 1'b0, es: 10'd127, p: 48'h7FFF_FFC0_0000, z: 1'b0}; want[3] = '{res: 32'h4000_0000, ovf: 1'b0, unf: 1'b0, inx: 1'b1};
      ops[4] = '{s: 1'b0, es: 10'd254, p: 48'h8000_0000_0000, z: 1'b0}; want[4] = '{res: 32'h7F80_0000, ovf: 1'b1, unf: 1'b0, inx: 1'b1};
      ops[5] = '{s: 1'b1, es: 10'd0,   p: 48'h4000_0000_0000, z: 1'b0}; want[5] = '{res: 32'h8000_0000, ovf: 1'b0, unf: 1'b1, inx: 1'b1};
      ops[6] = '{s: 1'b1, es: 10'd200, p: 48'hC123_4567_89AB, z: 1'b1}; want[6] = '{res: 32'h0000_0000, ovf: 1'b0, unf: 1'b0, inx: 1'b0};
      out_ready = 1'b1;
      while ((idx < 7 || got_q.size() < 7) && cyc < 40) begin
         if (idx < 7) drive(ops[idx], 1'b1); else drive('0, 1'b0);
         step(acc);
         if (acc) idx++;
         cyc++;
      end
      n_checks++; if (got_q.size() != 7) $display("FAIL directed_count got=%0d want=7", got_q.size()); else n_pass++;
      for (int i = 0; i < 7; i++) begin
         if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== want[i])
               $display("FAIL directed_%0d got=%h/%b want=%h/%b", i, got_q[i].res,
                        {got_q[i].ovf, got_q[i].unf, got_q[i].inx}, want[i].res, {want[i].ovf, want[i].unf, want[i].inx});
            else n_pass++;
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_backpressure();
      op_t  ops[5];
      bit   acc;
      int   idx = 0;
      int   cyc = 0;
      foreach (ops[i]) begin
         ops[i] = rand_op();
         ops[i].z = 1'b0;
      end
      out_ready = 1'b0;
      while (idx < 2 && cyc < 10) begin
         drive(ops[idx], 1'b1);
         step(acc);
         if (acc) idx++;
         cyc++;
      end
      drive(ops[idx], 1'b1);
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d got=%b want=0", k, in_ready); else n_pass++;
         n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid_%0d got=%b want=1", k, out_valid); else n_pass++;
         if (exp_q.size() > 0) begin
            n_checks++;
            if ({out_result, out_overflow, out_underflow, out_inexact} !== exp_q[0])
               $display("FAIL bp_hold_%0d got=%h want=%h", k, out_result, exp_q[0].res);
            else n_pass++;
         end
         step(acc);
         if (acc) idx++;
      end
      out_ready = 1'b1;
      cyc = 0;
      while ((idx < 5 || got_q.size() < 5) && cyc < 30) begin
         if (idx < 5) drive(ops[idx], 1'b1); else drive('0, 1'b0);
         step(acc);
         if (acc) idx++;
         cyc++;
      end
      n_checks++; if (got_q.size() != 5) $display("FAIL bp_count got=%0d want=5", got_q.size()); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         if (i < got_q.size() && i < exp_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL bp_order_%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            else n_pass++;
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_reset_midstream();
      bit acc;
      int idx = 0;
      int cyc = 0;
      out_ready = 1'b0;
      while (idx < 2 && cyc < 10) begin
         drive(rand_op(), 1'b1);
         step(acc);
         if (acc) idx++;
         cyc++;
      end
      n_checks++; if (!(out_valid === 1'b1 && in_ready === 1'b0)) $display("FAIL mid_full got=%b%b want=10", out_valid, in_ready); else n_pass++;
      rst = 1'b1;
      drive('0, 1'b0);
      step(acc);
      rst = 1'b0;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got=%b want=0", out_valid); else n_pass++;
      n_checks++; if (out_result !== 32'h0) $display("FAIL mid_out_result got=%h want=00000000", out_result); else n_pass++;
      n_checks++;
      if ({out_overflow, out_underflow, out_inexact} !== 3'b000)
         $display("FAIL mid_flags got=%b want=000", {out_overflow, out_underflow, out_inexact});
      else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got=%b want=1", in_ready); else n_pass++;
      exp_q.delete();
      got_q.delete();
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) step(acc);
      n_checks++; if (got_q.size() != 0) $display("FAIL mid_stale got=%0d want=0", got_q.size()); else n_pass++;
      drive('{s: 1'b1, es: 10'd130, p: 48'hA5A5_A5A5_A5A5, z: 1'b0}, 1'b1);
      step(acc);
      drive('0, 1'b0);
      cyc = 0;
      while (got_q.size() < 1 && cyc < 10) begin
         step(acc);
         cyc++;
      end
      n_checks++;
      if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0])
         $display("FAIL mid_recover got=%0d results want=1 matching model", got_q.size());
      else n_pass++;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_random();
      bit acc;
      int cyc = 0;
      int mism = 0;
      for (int k = 0; k < 600; k++) begin
         out_ready = ($urandom_range(0, 9) < 7);
         drive(rand_op(), $urandom_range(0, 9) < 7);
         step(acc);
      end
      drive('0, 1'b0);
      out_ready = 1'b1;
      while (got_q.size() < exp_q.size() && cyc < 20) begin
         step(acc);
         cyc++;
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            if (mism < 10) $display("FAIL rand_%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            mism++;
         end else n_pass++;
      end
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_directed();
      test_backpressure();
      test_reset_midstream();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fpm_round_stage.md
Name: fpm_round_stage

Overview:
- Pipelined normalise/round/pack stage directly downstream of the single-precision floating-point multiplier datapath.
- Consumes the raw 48-bit significand product, the un-wrapped biased exponent sum, the result sign and a zero flag.
- Produces an IEEE-754 binary32 result rounded to nearest, ties to even, plus exception flags.
- Two register stages with a valid/ready handshake; accepts one operation per cycle.

Parameters:
- EXP_W, 10, width of signed exponent-sum input (two's complement).
- MANT_W, 24, significand width including hidden bit; product width is 2*MANT_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  stage can accept an input this cycle.
- in_sign  in  1  result sign (A sign XOR B sign).
- in_exp_sum  in  EXP_W  Ea+Eb-127, signed, no wrap; legal range -126..381.
- in_mant_prod  in  2*MANT_W  product of the two 24-bit significands, value in [2^46, 2^48).
- in_zero  in  1  either operand is zero; forces a zero result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  32  packed {sign, exp[7:0], frac[22:0]}.
- out_overflow  out  1  result saturated to infinity.
- out_underflow  out  1  result flushed to zero.
- out_inexact  out  1  rounding discarded nonzero bits.

Behaviour:
Reset:
- rst=1 at an edge clears v1, v2, out_result, and all flags to 0.
- Reset applies mid-operation; in-flight data is discarded.
- in_ready is 1 the cycle after reset.

Handshake:
- adv2 = !v2 | out_ready.
- adv1 = !v1 | adv2.
- in_ready = adv1 (combinational from out_ready).
- Input is accepted when in_valid & in_ready.
- Stage 1 loads when adv1 and sets v1 = in_valid.
- Stage 2 loads from stage 1 when adv2 and sets v2 = v1.
- out_valid = v2.
- While out_valid & !out_ready: out_result and flags hold stable; a full stage 1 also holds.
- Latency is 2 cycles: data accepted at edge k is on the outputs after edge k+1.
- Full throughput with out_ready held high.
- Order is always preserved; no drops, no duplicates.

Stage 1 (normalise):
- If P[47]=1: mant = P[47:24], G = P[23], S = |P[22:0], e = exp_sum+1.
- Else: mant = P[46:23], G = P[22], S = |P[21:0], e = exp_sum.
- e is held at EXP_W+1 bits signed.
- sign and zero are registered alongside.

Stage 2 (round/pack):
- up = G & (S | mant[0]); m25 = mant + up.
- If m25[24]=1: m = m25[24:1], e = e+1.
- Priority, highest first:
  1. zero=1: result 32'h00000000 (positive zero), all flags 0.
  2. e >= 255: result {sign, 8'hFF, 23'h0}, overflow=1, inexact=1.
  3. e <= 0: result {sign, 31'h0}, underflow=1, inexact=1 (no subnormals).
  4. Otherwise: result {sign, e[7:0], m[22:0]}, inexact = G|S.
- The overflow check uses the post-round exponent.
- Rounding carry into e=255 gives overflow.

Boundary conditions:
- Simultaneous accept and drain in the same cycle is legal.
- A full pipeline with out_ready=1 keeps in_ready=1.
- Both stages full with out_ready=0 forces in_ready=0.
- Inputs are ignored when in_valid=0 or in_ready=0.

Test Plan:
- 1.5×1.5: P=0x900000000000, exp_sum=127, sign=0 -> after 2 cycles out_result=0x40100000, all flags 0.
- Tie-to-even:
  - P=0x400000400000, exp_sum=127 -> 0x3F800000, inexact=1.
  - P=0x400000C00000 -> 0x3F800002, inexact=1.
- Round carry: P=0x7FFFFFC00000, exp_sum=127 -> renormalise, out_result=0x40000000, inexact=1.
- Exceptions:
  - exp_sum=254, P=0x800000000000, sign=0 -> 0x7F800000, overflow=1.
  - exp_sum=0, P=0x400000000000, sign=1 -> 0x80000000, underflow=1.
  - in_zero=1 with any P -> 0x00000000, flags 0.
- Backpressure: stream 5 back-to-back ops, hold out_ready=0 for 3 cycles -> in_ready drops once both stages are full; all 5 results emerge in order, each held stable while stalled.
- Reset mid-stream: assert rst with v1=v2=1 -> next cycle out_valid=0, out_result=0, flags 0, in_ready=1; no stale result appears afterwards.
